// File: rtl/packet_capture_gate.sv
// Pre-trigger capture gate: delays samples by PRETRIG, emits CAPTURE_LEN-beat frames on detect; PCG_TIMESTAMP_EN adds a header beat.
// Latency: one clock from a valid input sample to its delayed sample on m_axis.
// Backpressure: input cannot stall; a sample arriving while the output beat is unaccepted is dropped and overflow is set.
module packet_capture_gate #(
  parameter int DATA_WIDTH  = 32,
  parameter int PRETRIG     = 64,
  parameter int CAPTURE_LEN = 1024,
  parameter int HOLDOFF     = 256
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  detect_in,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  overflow,
  input  logic                  overflow_clr,
  output logic [15:0]           frame_count,
  output logic [15:0]           missed_count
);

  localparam int PW = (PRETRIG > 1) ? $clog2(PRETRIG) : 1;
  localparam int FW = $clog2(PRETRIG + 1);
`ifdef PCG_TIMESTAMP_EN
  localparam int FRAME_BEATS = CAPTURE_LEN + 1;
`else
  localparam int FRAME_BEATS = CAPTURE_LEN;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_HOLDOFF} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] dly_ram [PRETRIG];
  logic [PW-1:0]         wr_ptr;
  logic [FW-1:0]         fill_cnt;
  logic [DATA_WIDTH-1:0] d_dat;
  logic [DATA_WIDTH-1:0] first_dat;
  logic [DATA_WIDTH-1:0] next_dat;
  logic [16:0]           beat_cnt;
  logic [15:0]           hold_cnt;
  logic                  filled;
  logic                  out_free;
  logic                  trig;
  logic                  busy_hit;
  logic                  last_load;

  // Reading the slot about to be overwritten yields the sample PRETRIG valid beats ago.
  assign d_dat = dly_ram[wr_ptr];

  always_ff @(posedge aclk) begin
    if (s_axis_tvalid) dly_ram[wr_ptr] <= s_axis_tdata;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
    end else if (s_axis_tvalid) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (!filled) fill_cnt <= fill_cnt + FW'(1);
    end
  end

`ifdef PCG_TIMESTAMP_EN
  logic [31:0]           ts_cnt;
  logic [DATA_WIDTH-1:0] pend_dat;

  // The header occupies the trigger slot, so data beats run one sample behind via pend_dat.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ts_cnt   <= '0;
      pend_dat <= '0;
    end else if (s_axis_tvalid) begin
      ts_cnt   <= ts_cnt + 32'd1;
      pend_dat <= d_dat;
    end
  end

  assign first_dat = DATA_WIDTH'(ts_cnt);
  assign next_dat  = pend_dat;
`else
  assign first_dat = d_dat;
  assign next_dat  = d_dat;
`endif

  assign filled    = (fill_cnt == FW'(PRETRIG));
  assign out_free  = !m_axis_tvalid || m_axis_tready;
  assign trig      = s_axis_tvalid && detect_in && enable && filled && (state == ST_IDLE);
  assign busy_hit  = s_axis_tvalid && detect_in && filled && (state != ST_IDLE);
  assign last_load = ((beat_cnt + 17'd1) == 17'(FRAME_BEATS));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= ST_IDLE;
      beat_cnt      <= '0;
      hold_cnt      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      overflow      <= 1'b0;
      frame_count   <= '0;
      missed_count  <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        if (m_axis_tlast) frame_count <= frame_count + 16'd1;
      end
      // Set paths below come later in the block so they win over a coincident clear.
      if (overflow_clr) overflow <= 1'b0;
      if (busy_hit && (missed_count != 16'hFFFF)) missed_count <= missed_count + 16'd1;

      case (state)
        ST_IDLE: begin
          if (trig) begin
            state <= ST_CAPTURE;
            if (out_free) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= first_dat;
              m_axis_tlast  <= 1'b0;
              beat_cnt      <= 17'd1;
            end else begin
              overflow <= 1'b1;
              beat_cnt <= '0;
            end
          end
        end
        ST_CAPTURE: begin
          if (s_axis_tvalid) begin
            if (out_free) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= next_dat;
              m_axis_tlast  <= last_load;
              beat_cnt      <= beat_cnt + 17'd1;
              if (last_load) begin
                hold_cnt <= '0;
                state    <= (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
              end
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        ST_HOLDOFF: begin
          if (s_axis_tvalid) begin
            if (hold_cnt == 16'(HOLDOFF - 1)) state <= ST_IDLE;
            else hold_cnt <= hold_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_capture_gate.sv
// Directed bench for packet_capture_gate: PRETRIG=4, CAPTURE_LEN=8, HOLDOFF=4, tdata = sample index.
module tb_packet_capture_gate;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        detect_in = 1'b0;
  logic        enable = 1'b1;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        overflow;
  logic        overflow_clr = 1'b0;
  logic [15:0] frame_count;
  logic [15:0] missed_count;

  packet_capture_gate #(
    .DATA_WIDTH(32), .PRETRIG(4), .CAPTURE_LEN(8), .HOLDOFF(4)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .detect_in(detect_in), .enable(enable),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .overflow(overflow), .overflow_clr(overflow_clr),
    .frame_count(frame_count), .missed_count(missed_count)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic [31:0] got_dat[$];
  logic        got_last[$];
  int          got_cyc[$];
  logic [31:0] exp_dat[$];
  logic        exp_last[$];
  int          det_list[$];
  int          present_cyc[0:255];
  int          stall_lo, stall_hi, en_off, sidx;
  int          n_vec = 0;
  int          n_err = 0;

  always @(negedge aclk) begin
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      got_dat.push_back(m_axis_tdata);
      got_last.push_back(m_axis_tlast);
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_det(input int i);
    foreach (det_list[j]) if (det_list[j] == i) return 1'b1;
    return 1'b0;
  endfunction

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk); #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'(sidx);
      detect_in     = is_det(sidx);
      enable        = (sidx < en_off);
      m_axis_tready = !((sidx >= stall_lo) && (sidx <= stall_hi));
      present_cyc[sidx % 256] = cyc;
      sidx++;
    end
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    detect_in     = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  task automatic do_reset();
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    detect_in     = 1'b0;
    enable        = 1'b1;
    m_axis_tready = 1'b1;
    overflow_clr  = 1'b0;
    repeat (2) @(posedge aclk);
    #3 areset = 1'b0;
    got_dat.delete(); got_last.delete(); got_cyc.delete();
    exp_dat.delete(); exp_last.delete(); det_list.delete();
    sidx = 0; stall_lo = 1000; stall_hi = -1; en_off = 1000;
  endtask

  task automatic push_frame(input int first);
    for (int i = 0; i < 8; i++) begin
      exp_dat.push_back(32'(first + i));
      exp_last.push_back(i == 7);
    end
  endtask

  task automatic check_beats(input string tag);
    int n;
    chk({tag, ".beats"}, 32'(got_dat.size()), 32'(exp_dat.size()));
    n = (got_dat.size() < exp_dat.size()) ? got_dat.size() : exp_dat.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.dat%0d", tag, i), got_dat[i], exp_dat[i]);
      chk($sformatf("%s.last%0d", tag, i), 32'(got_last[i]), 32'(exp_last[i]));
    end
  endtask

  initial begin
    do_reset();
    chk("rst.tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst.tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst.tdata", m_axis_tdata, 32'd0);
    chk("rst.overflow", 32'(overflow), 32'd0);
    chk("rst.frames", 32'(frame_count), 32'd0);
    chk("rst.missed", 32'(missed_count), 32'd0);

    // Basic frame with latency check
    det_list = '{20};
    stream(36);
    push_frame(16);
    check_beats("basic");
    if (got_cyc.size() > 0) chk("basic.latency", 32'(got_cyc[0] - present_cyc[20]), 32'd1);
    else chk("basic.latency_seen", 32'd0, 32'd1);
    chk("basic.frames", 32'(frame_count), 32'd1);
    chk("basic.overflow", 32'(overflow), 32'd0);
    chk("basic.missed", 32'(missed_count), 32'd0);

    // Detect before the delay line is full is ignored
    do_reset();
    det_list = '{2, 10};
    stream(26);
    push_frame(6);
    check_beats("fill");
    chk("fill.missed", 32'(missed_count), 32'd0);
    chk("fill.frames", 32'(frame_count), 32'd1);

    // Detects while busy are counted, then a second frame after hold-off
    do_reset();
    det_list = '{20, 25, 30, 40};
    stream(52);
    push_frame(16);
    push_frame(36);
    check_beats("busy");
    chk("busy.missed", 32'(missed_count), 32'd2);
    chk("busy.frames", 32'(frame_count), 32'd2);

    // Backpressure drops samples but keeps the frame length
    do_reset();
    det_list = '{20};
    stall_lo = 22; stall_hi = 24;
    stream(36);
    exp_dat  = '{32'd16, 32'd17, 32'd21, 32'd22, 32'd23, 32'd24, 32'd25, 32'd26};
    exp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    check_beats("ovf");
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk("ovf.frames", 32'(frame_count), 32'd1);
    @(posedge aclk); #1 overflow_clr = 1'b1;
    @(posedge aclk); #1 overflow_clr = 1'b0;
    chk("ovf.cleared", 32'(overflow), 32'd0);

    // Dropping enable mid-frame completes the frame, then stays idle
    do_reset();
    det_list = '{20, 40};
    en_off = 22;
    stream(52);
    push_frame(16);
    check_beats("en");
    chk("en.frames", 32'(frame_count), 32'd1);
    chk("en.missed", 32'(missed_count), 32'd0);

    // Reset in the middle of a frame
    do_reset();
    det_list = '{20};
    stream(23);
    chk("mid.pre_tdata", m_axis_tdata, 32'd18);
    chk("mid.pre_beats", 32'(got_dat.size()), 32'd2);
    areset = 1'b1;
    #1;
    chk("mid.tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("mid.tlast", 32'(m_axis_tlast), 32'd0);
    chk("mid.tdata", m_axis_tdata, 32'd0);
    chk("mid.frames", 32'(frame_count), 32'd0);
    do_reset();
    det_list = '{3, 4};
    stream(20);
    push_frame(0);
    check_beats("post");
    chk("post.frames", 32'(frame_count), 32'd1);
    chk("post.missed", 32'(missed_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
